// File: rtl/action_pkg.sv
// action_pkg
// Shared definitions for the action display path: scheduler state encoding
// and the 3-bit action codes understood by the 7-segment action decoder
// (A = bit 2, B = bit 1, C = bit 0).
package action_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SHOW = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  localparam logic [2:0] ACT_IDLE = 3'b000;
  localparam logic [2:0] ACT_1    = 3'b001;
  localparam logic [2:0] ACT_2    = 3'b010;
  localparam logic [2:0] ACT_3    = 3'b011;
  localparam logic [2:0] ACT_4    = 3'b100;
  localparam logic [2:0] ACT_5    = 3'b101;
  localparam logic [2:0] ACT_6    = 3'b110;
  localparam logic [2:0] ACT_7    = 3'b111;

  // Requester i owns action code i+1 (ACT_1 .. ACT_7).
  function automatic logic [2:0] act_for_req(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: grants the first set request bit at or
// after ptr, wrapping modulo N_REQ.
// Ports:
//   req          - request vector, N_REQ bits
//   ptr          - search start index (always < N_REQ)
//   grant_onehot - one-hot grant, zero when nothing requested
//   grant_idx    - index of the granted requester
//   any          - at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    cand         = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    if (any) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/action_scheduler.sv
// action_scheduler
// Shares the toy dog's action display between up to seven requesters.
// One requester is granted at a time in round-robin order; its action code
// is shown for DWELL_CYCLES, followed by GAP_CYCLES of IDLE_CODE.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - level requests, held until acknowledged
//   abort    - cuts the current SHOW phase short
//   ack      - one-cycle one-hot pulse to the granted requester
//   act_code - action code to the 7-segment action decoder
//   busy     - high while in SHOW or GAP
//   done     - one-cycle pulse when a SHOW phase ends
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | arbitrating; req sampled, IDLE_CODE shown
// ST_SHOW | grantee's code shown, counter runs down the dwell
// ST_GAP  | IDLE_CODE shown, counter runs down the gap
module action_scheduler
  import action_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000,
  parameter logic [2:0]  IDLE_CODE    = ACT_IDLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             abort,
  output logic [N_REQ-1:0] ack,
  output logic [2:0]       act_code,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [2:0]       act_q, act_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N_REQ-1:0] grant_onehot;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req          (req),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    act_d   = act_q;
    ack_d   = '0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        act_d = IDLE_CODE;
        if (grant_any) begin
          state_d = ST_SHOW;
          cnt_d   = DWELL_LOAD;
          act_d   = act_for_req(3'(grant_idx));
          ack_d   = grant_onehot;
          ptr_d   = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
        end
      end
      ST_SHOW: begin
        // Expiry and abort on the same edge collapse into one exit.
        if (cnt_q == '0 || abort) begin
          done_d = 1'b1;
          act_d  = IDLE_CODE;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        act_d = IDLE_CODE;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        act_d   = IDLE_CODE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      act_q   <= IDLE_CODE;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ack      = ack_q;
  assign act_code = act_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/action_scheduler.md
# action_scheduler

Sequencer that shares the toy dog's action display between up to seven requesters (buttons, sensor logic, demo FSM). Grants one requester at a time in round-robin order, holds that requester's 3-bit action code for a fixed dwell time, then inserts a blank gap before the next grant. Its `act_code` output drives the 3-bit action inputs (A = bit 2, B = bit 1, C = bit 0) of the 7-segment action decoder.

## Interface
- `N_REQ`, default 4: number of requesters, 1..7.
- `DWELL_CYCLES`, default 50_000_000: cycles an action code is held, at least 1.
- `GAP_CYCLES`, default 5_000_000: cycles of idle code between actions, 0 or more; 0 means no gap.
- `IDLE_CODE`, default 3'b000: code shown when no action is active.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: **asynchronous, active-low reset**.
- `req`, in, N_REQ: level requests. Bit i is held high until acknowledged.
- `abort`, in, 1: synchronous. Cuts the current action short.
- `ack`, out, N_REQ: one-hot, one-cycle pulse to the granted requester.
- `act_code`, out, 3: action code to the decoder. Requester i shows code i+1.
- `busy`, out, 1: high in SHOW and GAP.
- `done`, out, 1: one-cycle pulse when an action's SHOW phase ends, by expiry or abort.

## Operation
- **States:** IDLE, SHOW, GAP. Encoding is 2-bit binary.
- **Reset (async assert):** state = IDLE, `act_code` = IDLE_CODE, `ack` = 0, `busy` = 0, `done` = 0, rr pointer = 0, counter = 0. Deassertion takes effect synchronously.
- **IDLE:**
  - `req` is sampled only in IDLE.
  - If any bit is set, grant the first set bit at or after the rr pointer, wrapping modulo N_REQ.
  - Next cycle: state = SHOW, `act_code` = grantee+1, `ack[grantee]` = 1 for that cycle only, rr pointer = (grantee+1) mod N_REQ, counter = DWELL_CYCLES-1.
- **SHOW:**
  - The counter decrements each cycle.
  - The phase ends when the counter reaches 0 or `abort` = 1.
  - On the end edge: `done` pulses, and `act_code` = IDLE_CODE.
  - Next state is GAP with counter = GAP_CYCLES-1, or IDLE if GAP_CYCLES = 0.
- **GAP:** the counter decrements and `act_code` = IDLE_CODE. The state returns to IDLE at counter 0.
- **Request handling:**
  - Requests arriving during SHOW or GAP wait. They are not latched by the block.
  - A request that drops before it is granted is lost.
- **Counter:** unsigned, width $clog2(max(DWELL_CYCLES, GAP_CYCLES)+1). It never wraps; reaching 0 is always consumed as an exit.
- **Abort corner cases:**
  - `abort` in IDLE or GAP is ignored.
  - `abort` on the same cycle as natural expiry produces a single `done`.
- **Reset mid-action:** the action is dropped, and no `done` or `ack` is produced.

## Timing
- **Grant latency:** `req` high in IDLE at edge k gives `ack` and the new `act_code` valid after edge k+1.
- **SHOW duration:** `act_code` holds the action for exactly DWELL_CYCLES cycles when not aborted.
- **Abort latency:** `abort` sampled at edge k gives IDLE_CODE after edge k+1.
- **Back-to-back actions:** the minimum period is DWELL_CYCLES + GAP_CYCLES + 1 cycles, including the IDLE arbitration cycle.
- **Output registers:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Shared package/header `action_pkg`:**
  - state encodings: ST_IDLE, ST_SHOW, ST_GAP;
  - action code constants shared with the decoder: ACT_IDLE = 3'b000, ACT_1 through ACT_7.
- **Sub-module `rr_arbiter`:** combinational round-robin pick.
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: `grant_onehot`, `grant_idx`, `any`.
- **Top module:** FSM, counter, and output registers.

## Test plan
All scenarios use N_REQ=4, DWELL=4, GAP=2.
- **Single request:** `req` = 4'b0100 held. Required response:
  - `ack` = 4'b0100 for one cycle;
  - `act_code` = 3 for 4 cycles;
  - `done` pulses, then 000 for 2 cycles;
  - `busy` low afterwards.
- **Round-robin:** `req` = 4'b1111 held. Required response:
  - grants in order 0, 1, 2, 3, 0;
  - `act_code` sequence 1, 2, 3, 4, 1;
  - each grant is 7 cycles after the previous one.
- **Abort:** `abort` asserted 2 cycles into SHOW. Required response: `act_code` = 000 on the next cycle, one `done`, and a gap of 2 cycles. `abort` in IDLE has no effect.
- **GAP_CYCLES=0 variant with `req` = 4'b0001 held:** `act_code` goes 1 → 000 for 1 cycle (IDLE) → 1.
- **Reset during SHOW:** `rst_n` low mid-cycle. Required response:
  - `act_code` = 000, `busy` = 0 immediately (asynchronous);
  - no `done`;
  - after release, the rr pointer is 0 and `req` = 4'b1010 grants requester 1 first.
- **Late request:** `req[2]` rises during GAP. It is granted on the first IDLE cycle, and `ack` arrives 1 cycle after IDLE.
